// File: rtl/fifo_pkg.sv
// Shared FIFO-side constants and types.
// Used by the FIFO and its write-port arbiter.
package fifo_pkg;

   localparam int DATA_WIDTH          = 8;
   localparam int FIFO_DEPTH          = 8;
   localparam int ARB_NUM_REQ_DEFAULT = 4;

   typedef enum logic {
      ARB_IDLE,
      ARB_GRANT
   } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request after `last`,
// searching cyclically upward.
module rr_pick #(
   parameter int  NUM_REQ = 4,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last,
   output logic [IW-1:0]      pick,
   output logic               any
);

   logic [IW-1:0] idx;

   // Walk offsets from farthest to nearest so the nearest wins.
   always_comb begin
      pick = '0;
      any  = 1'b0;
      idx  = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = IW'((int'(last) + k) % NUM_REQ);
         if (req[idx]) begin
            pick = idx;
            any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO
// write port among NUM_REQ valid/ready producers.
module fifo_wr_arbiter #(
   parameter int  NUM_REQ    = fifo_pkg::ARB_NUM_REQ_DEFAULT,
   parameter int  DATA_WIDTH = fifo_pkg::DATA_WIDTH,
   parameter int  BURST_MAX  = 4,
   localparam int IW         = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   output logic                          grant_active,
   output logic [IW-1:0]                 grant_id
);

   import fifo_pkg::*;

   localparam int CW = $clog2(BURST_MAX + 1);

   arb_state_t           state;
   logic [IW-1:0]        owner;
   logic [IW-1:0]        last;
   logic [CW-1:0]        beat_cnt;

   logic [IW-1:0]        pick;
   logic                 any;
   logic                 active;
   logic                 own_valid;
   logic [DATA_WIDTH-1:0] own_data;
   logic                 accept;
   logic                 burst_end;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req  (req_valid),
      .last (last),
      .pick (pick),
      .any  (any)
   );

   // Gating on rst_n keeps a reset cycle from accepting a beat.
   always_comb begin
      active    = rst_n && (state == ARB_GRANT);
      own_valid = req_valid[owner];
      own_data  = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
      accept    = active && own_valid && !fifo_full;
      burst_end = (beat_cnt == CW'(BURST_MAX - 1));
   end

   always_comb begin
      req_ready = '0;
      if (active && !fifo_full)
         req_ready[owner] = 1'b1;
      fifo_wr_en   = accept;
      fifo_wr_data = accept ? own_data : '0;
      grant_active = active;
      grant_id     = active ? owner : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ARB_IDLE;
         owner    <= '0;
         beat_cnt <= '0;
         last     <= IW'(NUM_REQ - 1);
      end else begin
         unique case (state)
            ARB_IDLE: begin
               if (any) begin
                  state    <= ARB_GRANT;
                  owner    <= pick;
                  beat_cnt <= '0;
               end
            end
            ARB_GRANT: begin
               if (accept)
                  beat_cnt <= beat_cnt + CW'(1);
               if ((accept && burst_end) || !own_valid) begin
                  state <= ARB_IDLE;
                  last  <= owner;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule
